// File: rtl/seg7_output_port.sv
// seg7_output_port: CPU display port to eight 7-seg digits, hex or decimal (double-dabble when SEG7_DECIMAL_EN is defined).
// Latency: hex write 1 cycle; decimal write 33 cycles (32 CONV steps + LOAD); busy high while converting.
// Backpressure: none; writes during a conversion land in a single-entry pending buffer, last write wins.
module seg7_output_port #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        mode,
  output logic [31:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  // Displayed digits; r_dig_vld keeps the panel dark until the first write.
  logic [31:0]      r_dig;
  logic             r_dig_vld;
  logic [31:0]      r_value;
  logic [7:0][6:0]  w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'h40;
      4'h1: f_seg = 7'h79;
      4'h2: f_seg = 7'h24;
      4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;
      4'h5: f_seg = 7'h12;
      4'h6: f_seg = 7'h02;
      4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;
      4'h9: f_seg = 7'h10;
      4'hA: f_seg = 7'h08;
      4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;
      4'hD: f_seg = 7'h21;
      4'hE: f_seg = 7'h06;
      default: f_seg = 7'h0E;
    endcase
  endfunction

`ifdef SEG7_DECIMAL_EN
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_sh;
  logic [39:0]  r_bcd;
  logic [39:0]  w_bcd_adj;
  logic [4:0]   r_cnt;
  logic         r_ovf;
  logic         r_busy;
  logic         r_pnd_vld;
  logic         r_pnd_mode;
  logic [31:0]  r_pnd_dat;
  logic         w_launch;
  logic         w_launch_pnd;
  logic         w_launch_mode;
  logic [31:0]  w_launch_dat;
  logic         w_capture;

  // Pick what starts this cycle: pending entry first, else a direct write from IDLE.
  // LOAD only launches a pending decimal write; a pending hex write waits for IDLE
  // so it is not overwritten by LOAD's own digit update.
  always_comb begin
    w_launch      = 1'b0;
    w_launch_pnd  = 1'b0;
    w_launch_mode = 1'b0;
    w_launch_dat  = 32'd0;
    w_capture     = 1'b0;
    if (r_pnd_vld && ((r_state == S_IDLE) || ((r_state == S_LOAD) && r_pnd_mode))) begin
      w_launch      = 1'b1;
      w_launch_pnd  = 1'b1;
      w_launch_mode = r_pnd_mode;
      w_launch_dat  = r_pnd_dat;
    end else if ((r_state == S_IDLE) && we) begin
      w_launch      = 1'b1;
      w_launch_mode = mode;
      w_launch_dat  = wdata;
    end
    w_capture = we && !((r_state == S_IDLE) && !r_pnd_vld);
  end

  // Double-dabble add-3 on every BCD digit that is 5 or more, ahead of the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 10; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch && w_launch_mode) w_state_nxt = S_CONV;
      S_CONV:  if (r_cnt == 5'd31) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = w_launch ? S_CONV : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    r_busy = (r_state != S_IDLE);
  end

  // Single-entry pending buffer, overwritten by newer writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pnd_vld  <= 1'b0;
      r_pnd_mode <= 1'b0;
      r_pnd_dat  <= 32'd0;
    end else if (w_capture) begin
      r_pnd_vld  <= 1'b1;
      r_pnd_mode <= mode;
      r_pnd_dat  <= wdata;
    end else if (w_launch_pnd) begin
      r_pnd_vld  <= 1'b0;
    end
  end

  // Datapath: launch, conversion steps and LOAD of the low eight BCD digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= 32'd0;
      r_dig     <= 32'd0;
      r_dig_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_sh      <= 32'd0;
      r_bcd     <= 40'd0;
      r_cnt     <= 5'd0;
    end else begin
      if (r_state == S_LOAD) begin
        r_dig     <= r_bcd[31:0];
        r_dig_vld <= 1'b1;
        r_ovf     <= |r_bcd[39:32];
      end
      if (w_launch) begin
        r_value <= w_launch_dat;
        if (w_launch_mode) begin
          r_sh  <= w_launch_dat;
          r_bcd <= 40'd0;
          r_cnt <= 5'd0;
        end else begin
          r_dig     <= w_launch_dat;
          r_dig_vld <= 1'b1;
          r_ovf     <= 1'b0;
        end
      end else if (r_state == S_CONV) begin
        {r_bcd, r_sh} <= {w_bcd_adj, r_sh} << 1;
        r_cnt         <= r_cnt + 5'd1;
      end
    end
  end

  assign busy = r_busy;
  assign ovf  = r_ovf;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  // Every write is hex: load digits and readback value directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= 32'd0;
      r_dig     <= 32'd0;
      r_dig_vld <= 1'b0;
    end else if (we) begin
      r_value   <= wdata;
      r_dig     <= wdata;
      r_dig_vld <= 1'b1;
    end
  end

  assign busy = 1'b0;
  assign ovf  = 1'b0;
`endif

  // Segment decode from the digit registers with optional leading-zero blanking.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (!r_dig_vld)
        w_seg[i] = 7'h7F;
      else if (BLANK_LZ && (i != 0) && ((r_dig >> (4*i)) == 32'd0))
        w_seg[i] = 7'h7F;
      else
        w_seg[i] = f_seg(r_dig[4*i +: 4]);
    end
  end

  assign value = r_value;
  assign HEX0  = w_seg[0];
  assign HEX1  = w_seg[1];
  assign HEX2  = w_seg[2];
  assign HEX3  = w_seg[3];
  assign HEX4  = w_seg[4];
  assign HEX5  = w_seg[5];
  assign HEX6  = w_seg[6];
  assign HEX7  = w_seg[7];

endmodule
